// File: rtl/encrypt_if.sv
// ---------------------------------------------------------------------------
// encrypt_if : bundle of the key/message/result signals around the RSA
//              encryption engine.
//   ready  start strobe (controller -> engine)
//   e      256-bit public exponent
//   n      256-bit modulus
//   M      256-bit plaintext
//   c      256-bit ciphertext (engine -> controller)
//   valid  c holds a finished result
// master: the key-exchange controller side. slave: the engine side.
// ---------------------------------------------------------------------------
interface encrypt_if;
  logic         ready;
  logic [255:0] e;
  logic [255:0] n;
  logic [255:0] M;
  logic [255:0] c;
  logic         valid;

  modport master (output ready, output e, output n, output M,
                  input  c, input valid);
  modport slave  (input  ready, input e, input n, input M,
                  output c, output valid);
endinterface

// File: rtl/encrypt.sv
// ---------------------------------------------------------------------------
// encrypt : 256-bit RSA public-key encryption, c = M^e mod n.
//   Right-to-left binary square-and-multiply built on two bit-serial
//   MSB-first interleaved modular multipliers running side by side.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    encrypt_if.slave : ready/e/n/M in, c/valid out
//
// Configuration
//   EARLY_EXIT_EN  defined   : loop stops once the remaining exponent is 0
//                             (k = bit length of e).
//                  undefined : loop always runs 256 iterations, so latency
//                             does not depend on e.
//   c is the same in both builds.
//
// Latency (ready sampling cycle counted as 1):
//   1 + 257*(1+k) + (k+1) + 1 cycles until valid rises.
// ---------------------------------------------------------------------------
module encrypt (
  input  logic     clk,
  input  logic     reset,
  encrypt_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_CHECK = 3'd2,
    ST_MUL   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t state_r;
  state_t state_nx_s;

  logic [255:0] e_r;
  logic [255:0] n_r;
  logic [255:0] base_r;
  logic [255:0] result_r;
  logic [255:0] p0_r;
  logic [255:0] p1_r;
  logic [255:0] a0_r;
  logic [255:0] a1_r;
  logic [8:0]   cnt_r;
`ifndef EARLY_EXIT_EN
  logic [8:0]   iter_r;
`endif
  logic [255:0] c_r;
  logic         valid_r;

  logic         latch_s;
  logic         mm_setup_s;
  logic         mm_run_s;
  logic         mm_last_s;
  logic         load_c_s;
  logic         loop_end_s;
  logic [255:0] b0_s;
  logic [255:0] p0_nx_s;
  logic [255:0] p1_nx_s;

  // One interleaved modmul step: P = 2P + abit*B, then subtract n up to
  // twice. With P < n and B < n the sum is below 3n < 2^258.
  function automatic logic [255:0] mm_step(input logic [255:0] p,
                                           input logic         abit,
                                           input logic [255:0] b,
                                           input logic [255:0] m);
    logic [257:0] t;
    logic [257:0] nn;
    nn = {2'b00, m};
    t  = {1'b0, p, 1'b0} + (abit ? {2'b00, b} : 258'd0);
    if (t >= nn) t = t - nn;
    if (t >= nn) t = t - nn;
    return t[255:0];
  endfunction

`ifdef EARLY_EXIT_EN
  assign loop_end_s = (e_r == 256'd0);
`else
  assign loop_end_s = (iter_r == 9'd256);
`endif

  // During INIT the squaring multiplier computes M*1 to reduce M below n.
  assign b0_s    = (state_r == ST_INIT) ? 256'd1 : base_r;
  assign p0_nx_s = mm_step(p0_r, a0_r[255], b0_s, n_r);
  assign p1_nx_s = mm_step(p1_r, a1_r[255], base_r, n_r);

  assign bus.c     = c_r;
  assign bus.valid = valid_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  state_nx_s = bus.ready ? ST_INIT : ST_IDLE;
      ST_INIT:  state_nx_s = mm_last_s ? ST_CHECK : ST_INIT;
      ST_CHECK: state_nx_s = loop_end_s ? ST_DONE : ST_MUL;
      ST_MUL:   state_nx_s = mm_last_s ? ST_CHECK : ST_MUL;
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Control strobes decoded from the state and the modmul cycle counter.
  always_comb begin
    latch_s    = 1'b0;
    mm_setup_s = 1'b0;
    mm_run_s   = 1'b0;
    mm_last_s  = 1'b0;
    load_c_s   = 1'b0;
    case (state_r)
      ST_IDLE: latch_s = bus.ready;
      ST_INIT, ST_MUL: begin
        mm_setup_s = (cnt_r == 9'd0);
        mm_run_s   = (cnt_r != 9'd0);
        mm_last_s  = (cnt_r == 9'd256);
      end
      ST_DONE: load_c_s = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand latch, the two multipliers, exponent shift, output.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_r      <= 256'd0;
      n_r      <= 256'd0;
      base_r   <= 256'd0;
      result_r <= 256'd0;
      p0_r     <= 256'd0;
      p1_r     <= 256'd0;
      a0_r     <= 256'd0;
      a1_r     <= 256'd0;
      cnt_r    <= 9'd0;
`ifndef EARLY_EXIT_EN
      iter_r   <= 9'd0;
`endif
      c_r      <= 256'd0;
      valid_r  <= 1'b0;
    end else if (latch_s) begin
      e_r      <= bus.e;
      n_r      <= bus.n;
      a0_r     <= bus.M;
      base_r   <= 256'd0;
      result_r <= 256'd0;
      cnt_r    <= 9'd0;
`ifndef EARLY_EXIT_EN
      iter_r   <= 9'd0;
`endif
      valid_r  <= 1'b0;
    end else if (mm_setup_s) begin
      p0_r  <= 256'd0;
      p1_r  <= 256'd0;
      cnt_r <= 9'd1;
      if (state_r == ST_MUL) begin
        a0_r <= base_r;
        a1_r <= result_r;
      end
    end else if (mm_run_s) begin
      p0_r <= p0_nx_s;
      p1_r <= p1_nx_s;
      a0_r <= {a0_r[254:0], 1'b0};
      a1_r <= {a1_r[254:0], 1'b0};
      if (mm_last_s) begin
        cnt_r  <= 9'd0;
        base_r <= p0_nx_s;
        if (state_r == ST_INIT) begin
          // 1 mod n; zero also covers the degenerate n == 0 case.
          result_r <= (n_r > 256'd1) ? 256'd1 : 256'd0;
        end else begin
          if (e_r[0]) begin
            result_r <= p1_nx_s;
          end
          e_r <= {1'b0, e_r[255:1]};
`ifndef EARLY_EXIT_EN
          iter_r <= iter_r + 9'd1;
`endif
        end
      end else begin
        cnt_r <= cnt_r + 9'd1;
      end
    end else if (load_c_s) begin
      c_r     <= result_r;
      valid_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_encrypt.sv
module tb_encrypt;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  encrypt_if bus ();
  encrypt dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [255:0] got,
                           input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int bitlen(input logic [255:0] v);
    int l = 0;
    for (int i = 0; i < 256; i++) if (v[i]) l = i + 1;
    return l;
  endfunction

  function automatic int exp_latency(input logic [255:0] ev);
    int k;
`ifdef EARLY_EXIT_EN
    k = bitlen(ev);
`else
    k = 256;
`endif
    return 1 + 257 * (1 + k) + (k + 1) + 1;
  endfunction

  // Reference: plain modular exponentiation on 512-bit arithmetic.
  function automatic logic [255:0] ref_modexp(input logic [255:0] ev,
                                               input logic [255:0] nv,
                                               input logic [255:0] mv);
    logic [511:0] b, r, nn;
    if (nv == 256'd0) return 256'd0;
    nn = {256'd0, nv};
    b  = {256'd0, mv} % nn;
    r  = 512'd1 % nn;
    for (int i = 0; i < 256; i++) begin
      if (ev[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic start_op(input logic [255:0] ev, input logic [255:0] nv,
                          input logic [255:0] mv);
    @(negedge clk);
    bus.e = ev; bus.n = nv; bus.M = mv; bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
  endtask

  // Start an operation and wait for valid; optionally pulse ready and
  // scramble the inputs while busy.
  task automatic run_op(input string tag, input logic [255:0] ev,
                        input logic [255:0] nv, input logic [255:0] mv,
                        input bit disturb, output logic [255:0] cout,
                        output int cyc);
    start_op(ev, nv, mv);
    check_val({tag, "_vclr"}, {255'd0, bus.valid}, 256'd0);
    cyc = 1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (disturb && (cyc == 100 || cyc == 400)) begin
        bus.ready = 1'b1; bus.e = rand256(); bus.n = rand256(); bus.M = rand256();
      end else begin
        bus.ready = 1'b0;
      end
      if (bus.valid) break;
      if (cyc > 70000) begin
        check_val({tag, "_timeout"}, 256'd0, 256'd1);
        break;
      end
    end
    bus.ready = 1'b0;
    cout = bus.c;
  endtask

  task automatic do_case(input string tag, input logic [255:0] ev,
                         input logic [255:0] nv, input logic [255:0] mv,
                         input logic [255:0] exp, input bit disturb);
    logic [255:0] cv;
    int cyc;
    run_op(tag, ev, nv, mv, disturb, cv, cyc);
    check_val({tag, "_c"}, cv, exp);
    check_val({tag, "_valid"}, {255'd0, bus.valid}, 256'd1);
    check_val({tag, "_lat"}, 256'(cyc), 256'(exp_latency(ev)));
  endtask

  initial begin
    logic [255:0] big_n, big_m, rn, rm, re;
    bit saw_valid;

    bus.ready = 1'b0; bus.e = 256'd0; bus.n = 256'd0; bus.M = 256'd0;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    check_val("rst_c", bus.c, 256'd0);
    check_val("rst_valid", {255'd0, bus.valid}, 256'd0);

    // Busy ready pulses and input changes must not disturb the run.
    do_case("e3", 256'd3, 256'd33, 256'd4, 256'd31, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check_val("hold_c", bus.c, 256'd31);
    check_val("hold_valid", {255'd0, bus.valid}, 256'd1);

    do_case("e1_red", 256'd1, 256'd33, 256'd40, 256'd7, 1'b0);
    do_case("e0", 256'd0, 256'd33, 256'd5, 256'd1, 1'b0);

    big_n = 256'h807DB78B_3C5A91E2_7F04D6B1_95E2C3A8_1B6F0D47_E29A5C13_6D8B4F70_A46D3421;
    big_m = 256'h00020312_4A5B6C7D_8E9FA0B1_C2D3E4F5_06172839_4A5B6C7D_48656c6c_006f2e2e;
    do_case("big", 256'h10001, big_n, big_m, ref_modexp(256'h10001, big_n, big_m), 1'b0);

    do_case("n0", 256'd7, 256'd0, 256'd9, 256'd0, 1'b0);

    // Abort mid-operation.
    start_op(256'd3, 256'd33, 256'd4);
    repeat (500) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_val("abort_c", bus.c, 256'd0);
    check_val("abort_valid", {255'd0, bus.valid}, 256'd0);
    saw_valid = 1'b0;
    repeat (600) begin
      @(posedge clk); #1;
      if (bus.valid) saw_valid = 1'b1;
    end
    check_val("abort_nopulse", {255'd0, saw_valid}, 256'd0);
    do_case("after_abort", 256'd3, 256'd33, 256'd4, 256'd31, 1'b0);

    // Randomized operands against the reference model.
    re = rand256();
    rn = rand256() | {1'b1, 255'd1};
    rm = rand256();
    do_case("rand", re, rn, rm, ref_modexp(re, rn, rm), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
